buceros_bus_mux: RTL and testbench

Parametrised single-master, N-slave bus multiplexer with registered address decode, per-slave acknowledge handshake, timeout watchdog and error reporting. It replaces the fixed combinational RAM/GPIO select logic between the core's data-memory port and its peripherals. Slaves may now insert arbitrary wait states. Unmapped or unresponsive accesses complete with an error instead of hanging the core.

---
 rtl/buceros_bus_mux.sv | 173 +++++++++++++++++
 tb/tb_buceros_bus_mux.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buceros_bus_mux.sv
`default_nettype none
// ============================================================================
// Module   : buceros_bus_mux
// Brief    : Single-master, N-slave bus multiplexer with registered decode,
//            per-slave ack handshake, timeout watchdog and error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module buceros_bus_mux #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SEL_W      = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_req_i,
    input  logic                         m_we_i,
    input  logic [ADDR_W-1:0]            m_addr_i,
    input  logic [DATA_W-1:0]            m_wdata_i,
    input  logic [DATA_W/8-1:0]          m_wsel_i,
    output logic                         m_ack_o,
    output logic [DATA_W-1:0]            m_rdata_o,
    output logic                         m_err_o,
    output logic [NUM_SLAVES-1:0]        slv_req_o,
    output logic                         slv_we_o,
    output logic [ADDR_W-1:0]            slv_addr_o,
    output logic [DATA_W-1:0]            slv_wdata_o,
    output logic [DATA_W/8-1:0]          slv_wsel_o,
    input  logic [NUM_SLAVES-1:0]        slv_ack_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata_i,
    output logic [7:0]                   err_count_o,
    output logic [ADDR_W-1:0]            err_addr_o
);

    localparam int c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_tmo     = c_cnt_w'(TIMEOUT);
    localparam logic [SEL_W:0]     c_num_slv = (SEL_W + 1)'(NUM_SLAVES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [NUM_SLAVES-1:0]   r_slv_req;
    logic                    r_we;
    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic [DATA_W/8-1:0]     r_wsel;
    logic [DATA_W-1:0]       r_rdata;
    logic                    r_err;
    logic [7:0]              r_err_count;
    logic [ADDR_W-1:0]       r_err_addr;

    logic [SEL_W-1:0]        w_idx;
    logic                    w_dec_err;
    logic [NUM_SLAVES-1:0]   w_onehot;
    logic                    w_hit;
    logic                    w_tmo;
    logic [DATA_W-1:0]       w_sel_rdata;
    logic                    w_accept;
    logic                    w_ok;
    logic                    w_fail;

    assign w_idx     = m_addr_i[ADDR_W-1 -: SEL_W];
    assign w_dec_err = ({1'b0, w_idx} >= c_num_slv);
    // Only the selected slave can complete: stray acks are masked by the one-hot request.
    assign w_hit     = |(slv_ack_i & r_slv_req);
    assign w_tmo     = (TIMEOUT != 0) && (r_cnt == c_tmo);

    always_comb begin
        w_onehot    = '0;
        w_sel_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            w_onehot[k] = (w_idx == SEL_W'(k));
            w_sel_rdata = w_sel_rdata | (slv_rdata_i[k*DATA_W +: DATA_W] & {DATA_W{r_slv_req[k]}});
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ok        = 1'b0;
        w_fail      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m_req_i) begin
                    w_accept = 1'b1;
                    if (w_dec_err) begin
                        w_fail      = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (w_hit) begin
                    w_ok        = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_tmo) begin
                    w_fail      = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_slv_req   <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wsel      <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_err_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we    <= m_we_i;
                r_addr  <= m_addr_i;
                r_wdata <= m_wdata_i;
                r_wsel  <= m_wsel_i;
                r_cnt   <= '0;
                if (!w_dec_err) begin
                    r_slv_req <= w_onehot;
                end
            end
            // The counter stops at TIMEOUT (or stays at 0 when disabled) so it never wraps.
            if (r_state == ST_BUSY && !w_hit && !w_tmo && TIMEOUT != 0) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (w_ok) begin
                r_slv_req <= '0;
                r_rdata   <= r_we ? '0 : w_sel_rdata;
                r_err     <= 1'b0;
            end
            if (w_fail) begin
                r_slv_req  <= '0;
                r_rdata    <= '0;
                r_err      <= 1'b1;
                r_err_addr <= (r_state == ST_IDLE) ? m_addr_i : r_addr;
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign m_ack_o     = (r_state == ST_RESP);
    assign m_rdata_o   = r_rdata;
    assign m_err_o     = r_err;
    assign slv_req_o   = r_slv_req;
    assign slv_we_o    = r_we;
    assign slv_addr_o  = r_addr;
    assign slv_wdata_o = r_wdata;
    assign slv_wsel_o  = r_wsel;
    assign err_count_o = r_err_count;
    assign err_addr_o  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_buceros_bus_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_buceros_bus_mux
// Brief    : Self-checking bench for buceros_bus_mux with a transaction-level
//            reference model and randomized slave latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buceros_bus_mux;

    localparam int TMO = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         m_req, m_we, m_ack, m_err;
    logic [31:0]  m_addr, m_wdata, m_rdata;
    logic [3:0]   m_wsel;
    logic [3:0]   slv_req;
    logic         slv_we;
    logic [31:0]  slv_addr, slv_wdata;
    logic [3:0]   slv_wsel;
    logic [3:0]   slv_ack;
    logic [127:0] slv_rdata;
    logic [7:0]   err_count;
    logic [31:0]  err_addr;

    int          checks = 0;
    int          errors = 0;
    int          model_cnt = 0;
    logic [31:0] model_eaddr = '0;

    always #5 clk = ~clk;

    buceros_bus_mux #(
        .NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32), .SEL_W(4), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_wsel_i(m_wsel), .m_ack_o(m_ack), .m_rdata_o(m_rdata), .m_err_o(m_err),
        .slv_req_o(slv_req), .slv_we_o(slv_we), .slv_addr_o(slv_addr),
        .slv_wdata_o(slv_wdata), .slv_wsel_o(slv_wsel), .slv_ack_i(slv_ack),
        .slv_rdata_i(slv_rdata), .err_count_o(err_count), .err_addr_o(err_addr)
    );

    // Transaction-level expectation: decode error, completion after delay, or watchdog expiry.
    task automatic model_txn(input logic we, input logic [31:0] addr, input int delay,
                             input logic [127:0] data, output int lat, output logic err,
                             output logic [31:0] rd, output int reqc);
        int idx;
        idx = int'(addr[31:28]);
        if (idx >= 4) begin
            err = 1'b1; rd = '0; lat = 1; reqc = 0;
        end else if (delay >= 0 && delay <= TMO) begin
            err = 1'b0; rd = we ? 32'h0 : data[idx*32 +: 32]; lat = delay + 2; reqc = delay + 1;
        end else begin
            err = 1'b1; rd = '0; lat = TMO + 2; reqc = TMO + 1;
        end
        if (err) begin
            model_cnt   = (model_cnt < 255) ? model_cnt + 1 : 255;
            model_eaddr = addr;
        end
    endtask

    // Drives one master access and plays the selected slave; returns what was observed.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wsel, input int delay, input int stray,
                           output int lat, output logic err, output logic [31:0] rdata,
                           output int reqc, output logic stable, output logic ack_after);
        int idx;
        idx = int'(addr[31:28]);
        m_we = we; m_addr = addr; m_wdata = wdata; m_wsel = wsel; m_req = 1'b1;
        lat = -1; err = 1'b0; rdata = '0; reqc = 0; stable = 1'b1; ack_after = 1'b0;
        slv_ack = '0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            slv_ack = '0;
            if (m_ack) begin
                lat = n; err = m_err; rdata = m_rdata; m_req = 1'b0;
                break;
            end
            if (slv_req != 4'b0) begin
                reqc++;
                if (slv_we !== we || slv_addr !== addr || slv_wdata !== wdata || slv_wsel !== wsel)
                    stable = 1'b0;
                if (idx < 4 && slv_req[idx] && delay == reqc - 1) slv_ack[idx] = 1'b1;
            end
            if (stray >= 0) slv_ack[stray] = 1'b1;
        end
        m_req = 1'b0;
        slv_ack = '0;
        @(posedge clk); #1;
        ack_after = m_ack;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_wsel = '0;
        slv_ack = '0; slv_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m_ack, m_err, m_rdata, slv_req} !== '0) begin
            errors++; $display("FAIL reset_master: got %0h expected 0", {m_ack, m_err, m_rdata, slv_req});
        end
        checks++;
        if ({slv_we, slv_addr, slv_wdata, slv_wsel, err_count, err_addr} !== '0) begin
            errors++; $display("FAIL reset_slave: got %0h expected 0",
                               {slv_we, slv_addr, slv_wdata, slv_wsel, err_count, err_addr});
        end
        rst = 1'b0;
        model_cnt = 0; model_eaddr = '0;
    endtask

    task automatic test_read_zero_wait();
        int lat, reqc, elat, ereqc; logic err, st, aa, eerr; logic [31:0] rd, erd;
        slv_rdata = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
        model_txn(1'b0, 32'h1000_0004, 0, slv_rdata, elat, eerr, erd, ereqc);
        run_txn(1'b0, 32'h1000_0004, 32'h0, 4'hF, 0, -1, lat, err, rd, reqc, st, aa);
        checks++;
        if (lat !== 2 || reqc !== 1) begin
            errors++; $display("FAIL read0_latency: got lat %0d req %0d expected 2 1", lat, reqc);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
            errors++; $display("FAIL read0_data: got %0h err %0b expected deadbeef 0", rd, err);
        end
        checks++;
        if (aa !== 1'b0) begin
            errors++; $display("FAIL read0_ack_width: got %0b expected 0", aa);
        end
    endtask

    task automatic test_write_wait();
        int lat, reqc, elat, ereqc; logic err, st, aa, eerr; logic [31:0] rd, erd;
        slv_rdata = {4{32'hA5A5_5A5A}};
        model_txn(1'b1, 32'h0000_0010, 5, slv_rdata, elat, eerr, erd, ereqc);
        run_txn(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011, 5, -1, lat, err, rd, reqc, st, aa);
        checks++;
        if (lat !== 7 || reqc !== 6 || st !== 1'b1) begin
            errors++; $display("FAIL write_wait: got lat %0d req %0d stable %0b expected 7 6 1", lat, reqc, st);
        end
        checks++;
        if (err !== 1'b0 || rd !== 32'h0 || aa !== 1'b0) begin
            errors++; $display("FAIL write_resp: got err %0b rdata %0h after %0b expected 0 0 0", err, rd, aa);
        end
    endtask

    task automatic test_decode_err();
        int lat, reqc, elat, ereqc; logic err, st, aa, eerr; logic [31:0] rd, erd;
        model_txn(1'b0, 32'h4000_0000, 0, slv_rdata, elat, eerr, erd, ereqc);
        run_txn(1'b0, 32'h4000_0000, 32'h0, 4'hF, 0, -1, lat, err, rd, reqc, st, aa);
        checks++;
        if (lat !== 1 || reqc !== 0 || err !== 1'b1) begin
            errors++; $display("FAIL decode_err: got lat %0d req %0d err %0b expected 1 0 1", lat, reqc, err);
        end
        checks++;
        if (err_count !== 8'd1 || err_addr !== 32'h4000_0000) begin
            errors++; $display("FAIL decode_book: got cnt %0d addr %0h expected 1 40000000", err_count, err_addr);
        end
    endtask

    task automatic test_timeout();
        int lat, reqc, elat, ereqc; logic err, st, aa, eerr; logic [31:0] rd, erd;
        slv_rdata = {32'h0, 32'hCAFE_F00D, 32'h0, 32'h0};
        model_txn(1'b0, 32'h2000_0000, -1, slv_rdata, elat, eerr, erd, ereqc);
        run_txn(1'b0, 32'h2000_0000, 32'h0, 4'hF, -1, -1, lat, err, rd, reqc, st, aa);
        checks++;
        if (reqc !== 16 || lat !== 17 || err !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL timeout: got req %0d lat %0d err %0b rdata %0h expected 16 17 1 0", reqc, lat, err, rd);
        end
        checks++;
        if (err_count !== 8'(model_cnt) || err_addr !== 32'h2000_0000) begin
            errors++; $display("FAIL timeout_book: got cnt %0d addr %0h expected %0d 20000000", err_count, err_addr, model_cnt);
        end
        model_txn(1'b0, 32'h2000_0008, 15, slv_rdata, elat, eerr, erd, ereqc);
        run_txn(1'b0, 32'h2000_0008, 32'h0, 4'hF, 15, -1, lat, err, rd, reqc, st, aa);
        checks++;
        if (err !== 1'b0 || rd !== 32'hCAFE_F00D || lat !== 17) begin
            errors++; $display("FAIL ack_at_limit: got err %0b rdata %0h lat %0d expected 0 cafef00d 17", err, rd, lat);
        end
    endtask

    task automatic test_stray_ack();
        int lat, reqc, elat, ereqc; logic err, st, aa, eerr; logic [31:0] rd, erd;
        slv_rdata = {32'h3333_3333, 32'h0, 32'h1111_1111, 32'h0};
        model_txn(1'b0, 32'h1000_0020, 3, slv_rdata, elat, eerr, erd, ereqc);
        run_txn(1'b0, 32'h1000_0020, 32'h0, 4'hF, 3, 3, lat, err, rd, reqc, st, aa);
        checks++;
        if (lat !== 5 || err !== 1'b0 || rd !== 32'h1111_1111) begin
            errors++; $display("FAIL stray_ack: got lat %0d err %0b rdata %0h expected 5 0 11111111", lat, err, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] seen;
        m_we = 0; m_addr = 32'h5000_0000; m_wdata = '0; m_wsel = '0; m_req = 1'b1;
        seen = '0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            seen[n] = m_ack;
        end
        m_req = 1'b0;
        @(posedge clk); #1;
        model_cnt = (model_cnt + 2 > 255) ? 255 : model_cnt + 2;
        model_eaddr = 32'h5000_0000;
        checks++;
        if (seen !== 3'b101 || m_ack !== 1'b0) begin
            errors++; $display("FAIL back_to_back: got acks %b tail %0b expected 101 0", seen, m_ack);
        end
        checks++;
        if (err_count !== 8'(model_cnt)) begin
            errors++; $display("FAIL b2b_count: got %0d expected %0d", err_count, model_cnt);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic acked;
        m_we = 0; m_addr = 32'h2000_0000; m_req = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        m_req = 1'b0;
        checks++;
        if (slv_req !== 4'b0100) begin
            errors++; $display("FAIL midbusy_req: got %b expected 0100", slv_req);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({m_ack, m_err, m_rdata, slv_req, slv_we, slv_addr, slv_wdata, slv_wsel, err_count, err_addr} !== '0) begin
            errors++; $display("FAIL midbusy_reset: got %0h expected 0",
                {m_ack, m_err, m_rdata, slv_req, slv_we, slv_addr, slv_wdata, slv_wsel, err_count, err_addr});
        end
        acked = 1'b0;
        repeat (4) begin @(posedge clk); #1; acked |= m_ack; end
        checks++;
        if (acked !== 1'b0) begin
            errors++; $display("FAIL midbusy_noack: got %0b expected 0", acked);
        end
        model_cnt = 0; model_eaddr = '0;
    endtask

    task automatic test_random();
        int lat, reqc, elat, ereqc, delay, stray, idx; logic err, st, aa, eerr, we;
        logic [31:0] rd, erd, addr, wd; logic [3:0] ws;
        for (int t = 0; t < 40; t++) begin
            slv_rdata = {$urandom, $urandom, $urandom, $urandom};
            idx   = int'($urandom_range(0, 7));
            addr  = {4'(idx), 28'($urandom)};
            we    = 1'($urandom);
            wd    = $urandom;
            ws    = 4'($urandom);
            delay = int'($urandom_range(0, 20)) - 1;
            stray = ($urandom_range(0, 1) == 1) ? ((idx < 4) ? (idx + 1) % 4 : int'($urandom_range(0, 3))) : -1;
            model_txn(we, addr, delay, slv_rdata, elat, eerr, erd, ereqc);
            run_txn(we, addr, wd, ws, delay, stray, lat, err, rd, reqc, st, aa);
            checks++;
            if (lat !== elat || reqc !== ereqc || err !== eerr || rd !== erd || st !== 1'b1 || aa !== 1'b0) begin
                errors++;
                $display("FAIL rand_txn%0d: got lat %0d req %0d err %0b rd %0h st %0b aa %0b expected %0d %0d %0b %0h 1 0",
                         t, lat, reqc, err, rd, st, aa, elat, ereqc, eerr, erd);
            end
            checks++;
            if (err_count !== 8'(model_cnt) || err_addr !== model_eaddr) begin
                errors++; $display("FAIL rand_book%0d: got cnt %0d addr %0h expected %0d %0h",
                                   t, err_count, err_addr, model_cnt, model_eaddr);
            end
        end
    endtask

    task automatic test_saturation();
        int lat, reqc, elat, ereqc; logic err, st, aa, eerr; logic [31:0] rd, erd, addr;
        for (int t = 0; t < 300; t++) begin
            addr = {4'h8 + 4'($urandom_range(0, 7)), 28'(t)};
            model_txn(1'b0, addr, 0, slv_rdata, elat, eerr, erd, ereqc);
            run_txn(1'b0, addr, 32'h0, 4'h0, 0, -1, lat, err, rd, reqc, st, aa);
            if (t == 254) begin
                checks++;
                if (err_count !== 8'd255) begin
                    errors++; $display("FAIL sat_reach: got %0d expected 255", err_count);
                end
            end
        end
        checks++;
        if (err_count !== 8'd255 || err_addr !== model_eaddr) begin
            errors++; $display("FAIL saturation: got cnt %0d addr %0h expected 255 %0h", err_count, err_addr, model_eaddr);
        end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_decode_err();
        test_timeout();
        test_stray_ack();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
